counter_timer_param: RTL and testbench

Parametrised next-generation Caravel counter/timer core with configurable width, and usable as either a standalone timer or any word of a chained counter. Adds the following over the fixed 32-bit core:
- programmable prescaler;
- input capture with edge select;
- a generated chain strobe, so one block serves both low and high positions;
- a sticky status/IRQ scheme.
Sits behind the same wishbone register wrapper style (byte write enables from the bus decode).

---
 rtl/counter_timer_param.sv | 166 ++++++++++++++++
 tb/tb_counter_timer_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_timer_param.sv
// Parametrised counter/timer: prescaler, input capture, chain strobe.
// One block serves as standalone timer or any word of a chained counter.
module counter_timer_param #(
  parameter int WIDTH = 32,
  parameter int PRE_W = 16
) (
  input  logic               clkin,
  input  logic               resetn,
  input  logic               reg_cfg_we,
  input  logic [15:0]        reg_cfg_di,
  output logic [15:0]        reg_cfg_do,
  input  logic [WIDTH/8-1:0] reg_val_we,
  input  logic [WIDTH-1:0]   reg_val_di,
  output logic [WIDTH-1:0]   reg_val_do,
  input  logic [WIDTH/8-1:0] reg_dat_we,
  input  logic [WIDTH-1:0]   reg_dat_di,
  output logic [WIDTH-1:0]   reg_dat_do,
  input  logic               reg_pre_we,
  input  logic [PRE_W-1:0]   reg_pre_di,
  output logic [PRE_W-1:0]   reg_pre_do,
  output logic [WIDTH-1:0]   reg_cap_do,
  input  logic               capture_in,
  input  logic               enable_in,
  input  logic               count_in,
  input  logic               stop_in,
  output logic               enable_out,
  output logic               strobe_out,
  output logic               stop_out,
  output logic               irq_out
);

  localparam int NB = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [7:0]       cfg;
  logic             cap_flag;
  logic [WIDTH-1:0] value_reset;
  logic [WIDTH-1:0] value_cur;
  logic [WIDTH-1:0] cap_val;
  logic [PRE_W-1:0] pre_div;
  logic [PRE_W-1:0] pre_cnt;
  logic             strobe_q;
  logic             irq_q;
  logic [2:0]       cap_sync;

  logic [WIDTH-1:0] val_merged;
  logic [WIDTH-1:0] dat_merged;
  logic             loc_enable;
  logic             dat_wr;
  logic             en_clr;
  logic             pre_hit;
  logic             tick_raw;
  logic             tick;
  logic             terminal;
  logic             term_tick;
  logic             cap_seen;
  logic             cap_hit;
  logic             in_run;
  logic             in_load;
  logic             unused_ok;

  assign unused_ok = ^{reg_cfg_di[15:10], reg_cfg_di[8]};

  assign loc_enable = cfg[0] & (~cfg[3] | enable_in);
  assign dat_wr     = |reg_dat_we;
  assign en_clr     = reg_cfg_we & ~reg_cfg_di[0];
  assign pre_hit    = pre_cnt == pre_div;
  assign tick_raw   = cfg[3] ? (count_in & ~stop_in) : pre_hit;
  // A data write or an enable-clearing config write swallows the tick
  assign tick       = in_run & loc_enable & tick_raw & ~dat_wr & ~en_clr;
  assign terminal   = cfg[2] ? (value_cur == value_reset)
                             : (value_cur == '0);
  assign term_tick  = tick & terminal;
  assign cap_seen   = cfg[6] ? (~cap_sync[1] & cap_sync[2])
                             : (cap_sync[1] & ~cap_sync[2]);
  assign cap_hit    = cfg[5] & cap_seen;

  always_comb begin
    val_merged = value_reset;
    dat_merged = value_cur;
    for (int i = 0; i < NB; i++) begin
      if (reg_val_we[i]) val_merged[8*i +: 8] = reg_val_di[8*i +: 8];
      if (reg_dat_we[i]) dat_merged[8*i +: 8] = reg_dat_di[8*i +: 8];
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!loc_enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: state_nxt = LOAD;
        LOAD: state_nxt = RUN;
        RUN:  if (term_tick && cfg[1]) state_nxt = DONE;
        DONE: if (dat_wr) state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    in_run   = state == RUN;
    in_load  = state == LOAD;
    stop_out = state == DONE;
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      cfg         <= '0;
      cap_flag    <= 1'b0;
      value_reset <= '0;
      value_cur   <= '0;
      cap_val     <= '0;
      pre_div     <= '0;
      pre_cnt     <= '0;
      strobe_q    <= 1'b0;
      irq_q       <= 1'b0;
      cap_sync    <= '0;
    end else begin
      if (reg_cfg_we) cfg <= reg_cfg_di[7:0];
      if (reg_pre_we) pre_div <= reg_pre_di;
      value_reset <= val_merged;
      cap_sync    <= {cap_sync[1:0], capture_in};

      if (dat_wr) begin
        value_cur <= dat_merged;
      end else if (in_load) begin
        value_cur <= cfg[2] ? '0 : value_reset;
      end else if (term_tick) begin
        if (!cfg[1]) value_cur <= cfg[2] ? '0 : value_reset;
      end else if (tick) begin
        value_cur <= cfg[2] ? value_cur + WIDTH'(1)
                            : value_cur - WIDTH'(1);
      end

      if (!in_run || cfg[3] || dat_wr || pre_hit) pre_cnt <= '0;
      else                                        pre_cnt <= pre_cnt + PRE_W'(1);

      strobe_q <= term_tick;
      irq_q    <= (term_tick & cfg[4]) | (cap_hit & cfg[7]);

      if (cap_hit) cap_val <= value_cur;
      // Set beats clear when both land in the same cycle
      if (cap_hit)                          cap_flag <= 1'b1;
      else if (reg_cfg_we && reg_cfg_di[9]) cap_flag <= 1'b0;
    end
  end

  assign reg_cfg_do = {6'b0, cap_flag, stop_out, cfg};
  assign reg_val_do = value_reset;
  assign reg_dat_do = value_cur;
  assign reg_pre_do = pre_div;
  assign reg_cap_do = cap_val;
  assign enable_out = cfg[0];
  assign strobe_out = strobe_q;
  assign irq_out    = irq_q;

endmodule

// File: tb/tb_counter_timer_param.sv
// Bench for counter_timer_param: register table, closed-form
// counting model, capture, chaining and async reset.
module tb_counter_timer_param;

  logic clkin = 1'b0;
  logic resetn = 1'b0;
  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  logic        cfg_we, pre_we, cap_in;
  logic [15:0] cfg_di, pre_di;
  logic [3:0]  val_we, dat_we;
  logic [31:0] val_di, dat_di;
  logic        tie0 = 1'b0;
  wire  [15:0] cfg_do, pre_do;
  wire  [31:0] val_do, dat_do, cap_do;
  wire         en_out, strb, stop, irq;

  counter_timer_param #(.WIDTH(32), .PRE_W(16)) dut (
    .clkin(clkin), .resetn(resetn),
    .reg_cfg_we(cfg_we), .reg_cfg_di(cfg_di), .reg_cfg_do(cfg_do),
    .reg_val_we(val_we), .reg_val_di(val_di), .reg_val_do(val_do),
    .reg_dat_we(dat_we), .reg_dat_di(dat_di), .reg_dat_do(dat_do),
    .reg_pre_we(pre_we), .reg_pre_di(pre_di), .reg_pre_do(pre_do),
    .reg_cap_do(cap_do), .capture_in(cap_in),
    .enable_in(tie0), .count_in(tie0), .stop_in(tie0),
    .enable_out(en_out), .strobe_out(strb), .stop_out(stop),
    .irq_out(irq)
  );

  logic        l_cfg_we, h_cfg_we, l_val_we, h_val_we;
  logic [15:0] l_cfg_di, h_cfg_di;
  logic [7:0]  l_val_di, h_val_di;
  logic [7:0]  z8 = 8'h0;
  logic [15:0] z16 = 16'h0;
  logic        z1 = 1'b0;
  wire  [15:0] l_cfg_do, h_cfg_do, l_pre_do, h_pre_do;
  wire  [7:0]  l_val_do, h_val_do, l_dat_do, h_dat_do;
  wire  [7:0]  l_cap_do, h_cap_do;
  wire         l_en, l_strb, l_stop, l_irq;
  wire         h_en, h_strb, h_stop, h_irq;

  counter_timer_param #(.WIDTH(8)) lo (
    .clkin(clkin), .resetn(resetn),
    .reg_cfg_we(l_cfg_we), .reg_cfg_di(l_cfg_di), .reg_cfg_do(l_cfg_do),
    .reg_val_we(l_val_we), .reg_val_di(l_val_di), .reg_val_do(l_val_do),
    .reg_dat_we(z1), .reg_dat_di(z8), .reg_dat_do(l_dat_do),
    .reg_pre_we(z1), .reg_pre_di(z16), .reg_pre_do(l_pre_do),
    .reg_cap_do(l_cap_do), .capture_in(z1),
    .enable_in(z1), .count_in(z1), .stop_in(z1),
    .enable_out(l_en), .strobe_out(l_strb), .stop_out(l_stop),
    .irq_out(l_irq)
  );

  counter_timer_param #(.WIDTH(8)) hi (
    .clkin(clkin), .resetn(resetn),
    .reg_cfg_we(h_cfg_we), .reg_cfg_di(h_cfg_di), .reg_cfg_do(h_cfg_do),
    .reg_val_we(h_val_we), .reg_val_di(h_val_di), .reg_val_do(h_val_do),
    .reg_dat_we(z1), .reg_dat_di(z8), .reg_dat_do(h_dat_do),
    .reg_pre_we(z1), .reg_pre_di(z16), .reg_pre_do(h_pre_do),
    .reg_cap_do(h_cap_do), .capture_in(z1),
    .enable_in(l_en), .count_in(l_strb), .stop_in(l_stop),
    .enable_out(h_en), .strobe_out(h_strb), .stop_out(h_stop),
    .irq_out(h_irq)
  );

  int checks = 0;
  int errors = 0;
  int base = 0;

  task automatic chk(input string name, input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clkin);
    @(negedge clkin);
    cfg_we = 0; val_we = 0; pre_we = 0; dat_we = 0;
    l_cfg_we = 0; h_cfg_we = 0; l_val_we = 0; h_val_we = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cfg"}, cfg_do, 0);
    chk({tag, "_val"}, val_do, 0);
    chk({tag, "_dat"}, dat_do, 0);
    chk({tag, "_pre"}, pre_do, 0);
    chk({tag, "_cap"}, cap_do, 0);
    chk({tag, "_en"}, en_out, 0);
    chk({tag, "_strobe"}, strb, 0);
    chk({tag, "_stop"}, stop, 0);
    chk({tag, "_irq"}, irq, 0);
  endtask

  // Closed-form model: k ticks after RUN entry, one tick per p+1 cycles
  task automatic run_check(input longint r, input int p, input bit up,
                           input bit os, input bit ie,
                           input logic [7:0] extra, input int n);
    longint k, v;
    bit tk, st, sp;
    cfg_we = 1; cfg_di = 16'h0; cycle(); cycle();
    val_we = 4'hF; val_di = r[31:0]; pre_we = 1; pre_di = p[15:0];
    cycle();
    cfg_we = 1;
    cfg_di = {8'h0, extra | {3'b0, ie, 1'b0, up, os, 1'b1}};
    cycle(); cycle(); cycle();
    base = cyc;
    for (int j = 0; j <= n; j++) begin
      if (j > 0) cycle();
      k  = j / (p + 1);
      tk = (j > 0) && (j % (p + 1) == 0);
      if (!os) begin
        v  = up ? k % (r + 1) : r - k % (r + 1);
        st = tk && (k % (r + 1) == 0);
        sp = 0;
      end else begin
        v  = up ? ((k < r) ? k : r) : ((k < r) ? r - k : 0);
        st = tk && (k == r + 1);
        sp = k > r;
      end
      chk("value", dat_do, v);
      chk("strobe", strb, st);
      chk("irq", irq, ie && st);
      chk("stop", stop, sp);
    end
  endtask

  typedef struct {
    logic [15:0] cfg;
    logic [3:0]  vwe;
    logic [31:0] vdi;
    logic [15:0] pdi;
    logic [15:0] ecfg;
    logic [31:0] eval;
    logic [15:0] epre;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int c;
    longint r;
    int p;
    bit up, os, ie;
    cfg_we = 0; cfg_di = 0; val_we = 0; val_di = 0; dat_we = 0;
    dat_di = 0; pre_we = 0; pre_di = 0; cap_in = 0;
    l_cfg_we = 0; h_cfg_we = 0; l_val_we = 0; h_val_we = 0;
    l_cfg_di = 0; h_cfg_di = 0; l_val_di = 0; h_val_di = 0;

    tbl[0] = '{16'h0000, 4'hF, 32'h11223344, 16'h0007,
               16'h0000, 32'h11223344, 16'h0007};
    tbl[1] = '{16'h0088, 4'h1, 32'hAABBCCDD, 16'hBEEF,
               16'h0088, 32'h112233DD, 16'hBEEF};
    tbl[2] = '{16'hFE48, 4'h6, 32'h00EEFF00, 16'h0000,
               16'h0048, 32'h11EEFFDD, 16'h0000};
    tbl[3] = '{16'h01FF, 4'h8, 32'h99000000, 16'hFFFF,
               16'h00FF, 32'h99EEFFDD, 16'hFFFF};
    tbl[4] = '{16'h0034, 4'h0, 32'h12345678, 16'h1234,
               16'h0034, 32'h99EEFFDD, 16'h1234};

    repeat (2) @(negedge clkin);
    chk_all_zero("reset");
    resetn = 1;
    cycle();

    for (int i = 0; i < 5; i++) begin
      cfg_we = 1; cfg_di = tbl[i].cfg;
      val_we = tbl[i].vwe; val_di = tbl[i].vdi;
      pre_we = 1; pre_di = tbl[i].pdi;
      cycle();
      chk("tbl_cfg", cfg_do, tbl[i].ecfg);
      chk("tbl_val", val_do, tbl[i].eval);
      chk("tbl_pre", pre_do, tbl[i].epre);
      chk("tbl_en", en_out, tbl[i].ecfg[0]);
    end

    // Down continuous 3,2,1,0,3.. with irq
    run_check(3, 0, 0, 0, 1, 8'h00, 20);
    // Up oneshot with prescaler, then data write restarts from DONE
    run_check(5, 2, 1, 1, 1, 8'h00, 24);
    dat_we = 4'hF; dat_di = 32'h2; cycle();
    chk("done_wr_stop", stop, 0);
    chk("done_wr_val", dat_do, 2);
    run_check(5, 2, 1, 1, 0, 8'h00, 21);
    cfg_we = 1; cfg_di = 16'h0; cycle(); cycle();
    chk("clr_en_stop", stop, 0);
    chk("clr_en_val", dat_do, 5);

    // Byte write on a tick cycle wins over the decrement
    run_check(64'hFFFF0005, 0, 0, 0, 0, 8'h00, 5);
    dat_we = 4'b0011; dat_di = 32'h00001234; cycle();
    chk("bytewr_val", dat_do, 32'hFFFF1234);
    chk("bytewr_strobe", strb, 0);
    cycle();
    chk("bytewr_next", dat_do, 32'hFFFF1233);

    for (int it = 0; it < 8; it++) begin
      r  = longint'($urandom_range(0, 9));
      p  = int'($urandom_range(0, 3));
      up = 1'($urandom_range(0, 1));
      os = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      run_check(r, p, up, os, ie, 8'h00, int'($urandom_range(20, 45)));
    end

    // Capture: rising edge, irq_cap_ena
    run_check(200, 0, 1, 0, 0, 8'hA0, 5);
    repeat (4) cycle();
    c = cyc; cap_in = 1;
    cycle(); cycle();
    chk("cap_irq_early", irq, 0);
    cycle();
    chk("cap_rise_val", cap_do, (c + 2 - base) % 201);
    chk("cap_rise_flag", cfg_do, 16'h02A5);
    chk("cap_rise_irq", irq, 1);
    cycle();
    chk("cap_irq_once", irq, 0);
    cfg_we = 1; cfg_di = 16'h02A5; cycle();
    chk("cap_w1c", cfg_do, 16'h00A5);
    cfg_we = 1; cfg_di = 16'h00E5; cycle();
    repeat (3) cycle();
    chk("cap_no_rise", cfg_do, 16'h00E5);
    c = cyc; cap_in = 0;
    cycle(); cycle();
    cfg_we = 1; cfg_di = 16'h02E5; cycle();
    chk("cap_fall_val", cap_do, (c + 2 - base) % 201);
    chk("cap_set_wins", cfg_do, 16'h02E5);
    chk("cap_fall_irq", irq, 1);
    chk("cap_count", dat_do, (cyc - base) % 201);

    // Chain: high word steps once per low wrap
    l_val_we = 1; l_val_di = 8'hFF; h_val_we = 1; h_val_di = 8'hFF;
    cycle();
    l_cfg_we = 1; l_cfg_di = 16'h0005;
    h_cfg_we = 1; h_cfg_di = 16'h000D;
    cycle(); cycle(); cycle();
    for (int j = 0; j <= 520; j++) begin
      if (j > 0) cycle();
      chk("chain_lo", l_dat_do, j % 256);
      chk("chain_hi", h_dat_do, (j == 0) ? 0 : (j - 1) / 256);
    end

    // Async reset mid-count
    run_check(50, 1, 1, 0, 0, 8'h00, 10);
    #2 resetn = 0;
    #1 chk_all_zero("async");
    @(negedge clkin);
    resetn = 1;
    cycle(); cycle(); cycle();
    chk("post_rst_dat", dat_do, 0);
    chk("post_rst_cfg", cfg_do, 0);
    chk("post_rst_stop", stop, 0);
    chk("post_rst_hi", h_dat_do, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
